// File: rtl/bitwise_pipe.sv
// bitwise_pipe: parametrised, pipelined bitwise logic unit.
// One of eight per-bit operations is applied to x and y. The result and its
// zr/ng status flags travel through STAGES register stages under a
// valid/ready handshake, and empty stages collapse bubbles while stalled.
module bitwise_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  generate
    if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
      $error("bitwise_pipe: WIDTH must lie in 1..64");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_stages_check
      $error("bitwise_pipe: STAGES must lie in 1..4");
    end
  endgenerate

  // Stage registers: index 0 is the stage fed from the inputs,
  // index STAGES-1 drives the outputs.
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] zr_q;
  logic [STAGES-1:0] ng_q;
  logic [WIDTH-1:0]  data_q [STAGES];

  // Values each stage would load when it advances.
  logic [STAGES-1:0] prev_valid;
  logic [STAGES-1:0] prev_zr;
  logic [STAGES-1:0] prev_ng;
  logic [WIDTH-1:0]  prev_data [STAGES];

  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  result;
  logic              result_zr;
  logic              result_ng;

  // Per-bit operation selected by op; y does not matter for NOT and PASS.
  always_comb begin
    result = x;
    case (op)
      3'd0: result = ~x;
      3'd1: result = x & y;
      3'd2: result = x | y;
      3'd3: result = x ^ y;
      3'd4: result = ~(x & y);
      3'd5: result = ~(x | y);
      3'd6: result = ~(x ^ y);
      3'd7: result = x;
    endcase
  end

  // Flags are formed at capture so they stay paired with their data word.
  always_comb begin
    result_zr = (result == '0);
    result_ng = result[WIDTH-1];
  end

  // Ready chain: a stage may advance if it is empty or its successor advances.
  always_comb begin
    logic chain;
    adv = '0;
    chain = !valid_q[STAGES-1] || out_ready;
    adv[STAGES-1] = chain;
    for (int k = STAGES - 2; k >= 0; k--) begin
      chain = !valid_q[k] || chain;
      adv[k] = chain;
    end
  end

  // Upstream source for every stage: the input port for the first stage,
  // the preceding stage register for the rest.
  always_comb begin
    prev_valid = '0;
    prev_zr    = '0;
    prev_ng    = '0;
    for (int k = 0; k < STAGES; k++) begin
      prev_data[k] = '0;
    end
    prev_valid[0] = in_valid;
    prev_zr[0]    = result_zr;
    prev_ng[0]    = result_ng;
    prev_data[0]  = result;
    for (int k = 1; k < STAGES; k++) begin
      prev_valid[k] = valid_q[k-1];
      prev_zr[k]    = zr_q[k-1];
      prev_ng[k]    = ng_q[k-1];
      prev_data[k]  = data_q[k-1];
    end
  end

  // Stage registers load from upstream when they advance and hold otherwise;
  // reset discards every in-flight word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      zr_q    <= '0;
      ng_q    <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          valid_q[k] <= prev_valid[k];
          zr_q[k]    <= prev_zr[k];
          ng_q[k]    <= prev_ng[k];
          data_q[k]  <= prev_data[k];
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[STAGES-1];
  assign out       = data_q[STAGES-1];
  assign zr        = zr_q[STAGES-1];
  assign ng        = ng_q[STAGES-1];

endmodule

// File: tb/tb_bitwise_pipe.sv
// tb_bitwise_pipe: self-checking bench for bitwise_pipe.
// Three instances cover WIDTH/STAGES = 16/2, 37/3 and 1/1. A queue-based
// reference model per instance predicts every presented word and the
// expected in_ready level; directed sequences pin literal results.
module tb_bitwise_pipe;

  logic clk;
  logic reset;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_zr, a_ng;
  logic [2:0]  a_op;
  logic [15:0] a_x, a_y, a_out;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_zr, b_ng;
  logic [2:0]  b_op;
  logic [36:0] b_x, b_y, b_out;

  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_zr, c_ng;
  logic [2:0]  c_op;
  logic [0:0]  c_x, c_y, c_out;

  int tests = 0;
  int fails = 0;

  // Words accepted but not yet delivered, one queue per instance.
  logic [63:0] sb [3][$];

  bitwise_pipe #(.WIDTH(16), .STAGES(2)) u_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .op(a_op), .x(a_x), .y(a_y), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out(a_out), .zr(a_zr), .ng(a_ng));

  bitwise_pipe #(.WIDTH(37), .STAGES(3)) u_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .op(b_op), .x(b_x), .y(b_y), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out(b_out), .zr(b_zr), .ng(b_ng));

  bitwise_pipe #(.WIDTH(1), .STAGES(1)) u_c (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .op(c_op), .x(c_x), .y(c_y), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out(c_out), .zr(c_zr), .ng(c_ng));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result of one operation, truncated to w bits.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [63:0] xx,
                                        input logic [63:0] yy, input int w);
    logic [63:0] r;
    logic [63:0] mask;
    case (o)
      3'd0: r = ~xx;
      3'd1: r = xx & yy;
      3'd2: r = xx | yy;
      3'd3: r = xx ^ yy;
      3'd4: r = ~(xx & yy);
      3'd5: r = ~(xx | yy);
      3'd6: r = ~(xx ^ yy);
      default: r = xx;
    endcase
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return r & mask;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One cycle of the reference model for instance id of the given depth/width.
  task automatic scoreStep(input int id, input int depth, input int w,
                           input logic iv, input logic ir, input logic ov, input logic ordy,
                           input logic [2:0] o, input logic [63:0] xx, input logic [63:0] yy,
                           input logic [63:0] outv, input logic z, input logic n);
    int occ;
    logic [63:0] expv;
    occ = sb[id].size();
    checkOutput($sformatf("u%0d in_ready", id), 64'(ir), 64'(!(occ == depth && !ordy)));
    if (ov) begin
      checkOutput($sformatf("u%0d word pending", id), 64'(occ > 0), 64'd1);
      if (occ > 0) begin
        expv = sb[id][0];
        checkOutput($sformatf("u%0d out", id), outv, expv);
        checkOutput($sformatf("u%0d zr", id), 64'(z), 64'(expv == 64'd0));
        checkOutput($sformatf("u%0d ng", id), 64'(n), 64'(expv[w-1]));
        if (ordy) void'(sb[id].pop_front());
      end
    end
    if (iv && ir) sb[id].push_back(model(o, xx, yy, w));
  endtask

  // Compare process: every falling edge, each instance is checked against its model.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) sb[i].delete();
      checkOutput("reset a_in_ready", 64'(a_in_ready), 64'd1);
      checkOutput("reset b_out_valid", 64'(b_out_valid), 64'd0);
      checkOutput("reset c_in_ready", 64'(c_in_ready), 64'd1);
    end else begin
      scoreStep(0, 2, 16, a_in_valid, a_in_ready, a_out_valid, a_out_ready,
                a_op, 64'(a_x), 64'(a_y), 64'(a_out), a_zr, a_ng);
      scoreStep(1, 3, 37, b_in_valid, b_in_ready, b_out_valid, b_out_ready,
                b_op, 64'(b_x), 64'(b_y), 64'(b_out), b_zr, b_ng);
      scoreStep(2, 1, 1, c_in_valid, c_in_ready, c_out_valid, c_out_ready,
                c_op, 64'(c_x), 64'(c_y), 64'(c_out), c_zr, c_ng);
    end
  end

  // Present one word to instance A for a single cycle.
  task automatic applyStimulus(input logic [2:0] o, input logic [15:0] xx, input logic [15:0] yy);
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_op = o; a_x = xx; a_y = yy;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  // Single word into an empty A: output valid exactly two cycles after transfer.
  task automatic singleWordA(input string tag, input logic [2:0] o, input logic [15:0] xx,
                             input logic [15:0] yy, input logic [15:0] expOut,
                             input logic expZr, input logic expNg);
    applyStimulus(o, xx, yy);
    @(negedge clk);
    checkOutput({tag, " early valid"}, 64'(a_out_valid), 64'd0);
    @(negedge clk);
    checkOutput({tag, " valid"}, 64'(a_out_valid), 64'd1);
    checkOutput({tag, " out"}, 64'(a_out), 64'(expOut));
    checkOutput({tag, " zr"}, 64'(a_zr), 64'(expZr));
    checkOutput({tag, " ng"}, 64'(a_ng), 64'(expNg));
    @(negedge clk);
    checkOutput({tag, " late valid"}, 64'(a_out_valid), 64'd0);
  endtask

  task automatic drainCheck(input int id, input string tag);
    int cyc;
    cyc = 0;
    while (sb[id].size() != 0 && cyc < 30) begin
      @(negedge clk); #1;
      cyc++;
    end
    checkOutput({tag, " drained"}, 64'(sb[id].size()), 64'd0);
  endtask

  // Ops 1..7 back to back; results must appear on consecutive cycles.
  task automatic opSweepA();
    logic [15:0] expList [7];
    expList = '{16'hC0C0, 16'hFCFC, 16'h3C3C, 16'h3F3F, 16'h0303, 16'hC3C3, 16'h0000};
    fork
      begin
        for (int i = 0; i < 7; i++) begin
          @(posedge clk); #1;
          a_out_ready = 1'b1;
          a_in_valid  = 1'b1;
          a_op = 3'(i + 1);
          a_x  = (i == 6) ? 16'h0000 : 16'hF0F0;
          a_y  = 16'hCCCC;
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
      end
      begin
        int got;
        int first;
        int cyc;
        got = 0; first = 0; cyc = 0;
        while (got < 7 && cyc < 40) begin
          @(negedge clk);
          cyc++;
          if (a_out_valid) begin
            checkOutput($sformatf("sweep word %0d", got), 64'(a_out), 64'(expList[got]));
            if (got == 0) first = cyc;
            if (got == 6) begin
              checkOutput("sweep pass zr", 64'(a_zr), 64'd1);
              checkOutput("sweep pass ng", 64'(a_ng), 64'd0);
              checkOutput("sweep consecutive", 64'(cyc - first), 64'd6);
            end
            got++;
          end
        end
        checkOutput("sweep count", 64'(got), 64'd7);
      end
    join
  endtask

  // Stall the output with input held valid: exactly two words fit.
  task automatic capacityA();
    int cnt;
    logic acc;
    cnt = 0;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_op = 3'd7; a_x = 16'h0011; a_y = 16'h0000;
    repeat (6) begin
      @(negedge clk);
      acc = a_in_ready;
      @(posedge clk); #1;
      if (acc) begin
        cnt++;
        a_x = a_x + 16'd1;
      end
    end
    @(negedge clk);
    checkOutput("cap accepted", 64'(cnt), 64'd2);
    checkOutput("cap in_ready low", 64'(a_in_ready), 64'd0);
    checkOutput("cap head", 64'(a_out), 64'h0011);
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    @(negedge clk);
    checkOutput("cap in_ready release", 64'(a_in_ready), 64'd1);
    checkOutput("cap head release", 64'(a_out), 64'h0011);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    checkOutput("cap second", 64'(a_out), 64'h0012);
    drainCheck(0, "cap");
  endtask

  // Reset with two words in flight must clear the output at once.
  task automatic resetMidA();
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_op = 3'd7; a_x = 16'h0AAA; a_y = 16'h0000;
    @(posedge clk); #1;
    a_x = 16'h0BBB;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst in flight", 64'(a_out_valid), 64'd1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checkOutput("rst async valid", 64'(a_out_valid), 64'd0);
    checkOutput("rst async out", 64'(a_out), 64'd0);
    checkOutput("rst in_ready", 64'(a_in_ready), 64'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    a_out_ready = 1'b1;
    singleWordA("post reset", 3'd3, 16'h1234, 16'h00FF, 16'h12CB, 1'b0, 1'b0);
  endtask

  // Random valid/ready traffic into the 37-bit, 3-stage instance.
  task automatic randomB();
    int accepted;
    int cyc;
    logic acc;
    accepted = 0; cyc = 0; acc = 1'b0;
    while (accepted < 1000 && cyc < 20000) begin
      @(posedge clk); #1;
      if (!b_in_valid || acc) begin
        b_in_valid = 1'($urandom_range(0, 1));
        b_op = 3'($urandom_range(0, 7));
        b_x  = 37'({$urandom, $urandom});
        b_y  = 37'({$urandom, $urandom});
      end
      b_out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = b_in_valid && b_in_ready;
      if (acc) accepted++;
      cyc++;
    end
    @(posedge clk); #1;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    checkOutput("rand accepted", 64'(accepted), 64'd1000);
    drainCheck(1, "rand");
  endtask

  // Single-stage, single-bit instance: NOR of zeros and the one-word stall.
  task automatic tinyC();
    @(posedge clk); #1;
    c_out_ready = 1'b1;
    c_in_valid  = 1'b1;
    c_op = 3'd5; c_x = 1'b0; c_y = 1'b0;
    @(posedge clk); #1;
    c_in_valid = 1'b0;
    @(negedge clk);
    checkOutput("tiny valid", 64'(c_out_valid), 64'd1);
    checkOutput("tiny out", 64'(c_out), 64'd1);
    checkOutput("tiny ng", 64'(c_ng), 64'd1);
    checkOutput("tiny zr", 64'(c_zr), 64'd0);
    @(posedge clk); #1;
    c_out_ready = 1'b0;
    c_in_valid  = 1'b1;
    c_op = 3'd1; c_x = 1'b1; c_y = 1'b1;
    @(negedge clk);
    checkOutput("tiny empty ready", 64'(c_in_ready), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("tiny full ready", 64'(c_in_ready), 64'd0);
    checkOutput("tiny held out", 64'(c_out), 64'd1);
    @(posedge clk); #1;
    c_out_ready = 1'b1;
    @(negedge clk);
    checkOutput("tiny release ready", 64'(c_in_ready), 64'd1);
    @(posedge clk); #1;
    c_in_valid = 1'b0;
    drainCheck(2, "tiny");
  endtask

  initial begin
    reset = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_op = '0; a_x = '0; a_y = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_op = '0; b_x = '0; b_y = '0;
    c_in_valid = 1'b0; c_out_ready = 1'b0; c_op = '0; c_x = '0; c_y = '0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset out_valid", 64'(a_out_valid), 64'd0);
    checkOutput("reset out", 64'(a_out), 64'd0);
    checkOutput("reset zr", 64'(a_zr), 64'd0);
    checkOutput("reset ng", 64'(a_ng), 64'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    singleWordA("not", 3'd0, 16'h00FF, 16'h0000, 16'hFF00, 1'b0, 1'b1);
    opSweepA();
    capacityA();
    resetMidA();
    randomB();
    tinyC();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/bitwise_pipe.md
Name: bitwise_pipe

Overview:
- Parametrised, pipelined bitwise logic unit; successor to the fixed 16-bit inverter bank.
- Applies one of eight per-bit operations to operands x and y. Carries the result through STAGES register stages under a valid/ready handshake.
- Also produces Hack-style zr/ng status flags.
- Sits between operand sources and the datapath/ALU result bus wherever registered, back-pressurable bitwise logic is needed.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range 1..64.
- STAGES, 2, number of register stages from input to output; legal range 1..4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand word presented.
- in_ready  output  1  block accepts the operand word this cycle.
- op  input  3  operation select, sampled with the operand word.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- out_valid  output  1  result word presented.
- out_ready  input  1  consumer accepts the result this cycle.
- out  output  WIDTH  result.
- zr  output  1  result equals zero.
- ng  output  1  result MSB (out[WIDTH-1]).

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous and active-high.
- Op encoding (per bit i):
  - 0 NOT  out = ~x
  - 1 AND  out = x & y
  - 2 OR   out = x | y
  - 3 XOR  out = x ^ y
  - 4 NAND out = ~(x & y)
  - 5 NOR  out = ~(x | y)
  - 6 XNOR out = ~(x ^ y)
  - 7 PASS out = x
  - y is ignored for ops 0 and 7.
- Computation and flags:
  - The result is computed combinationally from x, y and op and captured into stage 1 on acceptance.
  - zr and ng are computed at capture and travel with the data.
- Pipeline: stages 1..STAGES, each holding {valid_k, data_k, zr_k, ng_k}. Stage STAGES drives out_valid, out, zr and ng directly from registers.
- Handshake:
  - Transfer in occurs when in_valid && in_ready.
  - Transfer out occurs when out_valid && out_ready.
  - in_valid must hold with stable x/y/op until accepted; out_valid obeys the same rule on the output side.
- Advance rule:
  - adv_STAGES = !valid_STAGES || out_ready.
  - adv_k = !valid_k || adv_(k+1) for k < STAGES.
  - in_ready = adv_1.
  - The combinational ready chain from out_ready to in_ready is permitted. No combinational path from in_valid to out_valid.
- Stage update on adv_k:
  - valid_k <= valid_(k-1), or in_valid for stage 1.
  - The data/flag payload loads with it.
  - If adv_k is low, the stage holds.
- Latency and throughput:
  - Exactly STAGES cycles from input transfer to out_valid when the pipeline is empty.
  - Sustained throughput is 1 word/cycle with out_ready held high.
  - No bubbles are inserted and none are required. Bubbles collapse when out_ready is low: an empty stage accepts even if downstream is stalled.
- Capacity: up to STAGES words held while out_ready is low. in_ready goes low only when all STAGES are valid and out_ready is low.
- Simultaneous events: when the pipeline is full and out_ready is high, the input transfer and output transfer both occur in the same cycle with no loss.
- Reset:
  - All valid_k = 0, all data = 0, zr = 0, ng = 0; out_valid = 0, out = 0.
  - in_ready reads 1 during and after reset.
  - Reset mid-stream discards all in-flight words. No partial words emerge.
- Width rules:
  - Results are exactly WIDTH bits; no extension or truncation.
  - WIDTH = 1 is legal: ng equals out[0] and zr equals ~out[0].
- Out-of-range parameters are a compile-time error.

Test Plan:
- Reset, then WIDTH=16, STAGES=2, op=0, x=16'h00FF, in_valid pulsed one cycle, out_ready=1 → out_valid high exactly 2 cycles later with out=16'hFF00, zr=0, ng=1; otherwise out_valid low.
- Back-to-back ops 1..6 on x=16'hF0F0, y=16'hCCCC, out_ready=1 → outputs on consecutive cycles: C0C0, FCFC, 3C3C, 3F3F, 0303, C3C3. Then op=7, x=0 → out=0000 with zr=1, ng=0.
- out_ready=0 with continuous in_valid → exactly STAGES words accepted, then in_ready=0. Release out_ready → words emerge in order, none lost or duplicated, and in_ready returns high the same cycle.
- Random in_valid/out_ready (50%) with 1000 random ops, WIDTH=37, STAGES=3 → scoreboard matches golden model in order; zr/ng match each word.
- Assert reset while 2 words are in flight → out_valid=0 immediately (asynchronous). After release, the next word has latency STAGES and no stale word appears.
- STAGES=1, WIDTH=1, op=5, x=0, y=0 → out=1, ng=1, zr=0 one cycle after acceptance. The full/stall case with out_ready=0 drops in_ready after one word.
